// File: rtl/key_debouncer.sv
// Push-button conditioner: per-key two-flop synchronizer, debounce state machine,
// and registered level / press / release / auto-repeat outputs.
module key_debouncer #(
    parameter int W_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int REPEAT_ENABLE   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_KEYS-1:0] in_keys,
    output logic              vcc_for_keys,
    output logic [W_KEYS-1:0] pressed,
    output logic [W_KEYS-1:0] press_pulse,
    output logic [W_KEYS-1:0] release_pulse,
    output logic [W_KEYS-1:0] repeat_pulse,
    output logic [W_KEYS-1:0] out_leds
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_PRE  = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] H_SAT  = HW'(HOLD_CYCLES);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
    localparam logic          REP_EN = (REPEAT_ENABLE != 0);

    localparam logic [1:0] ST_RELEASED    = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
    localparam logic [1:0] ST_PRESSED     = 2'd2;
    localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

    assign vcc_for_keys = 1'b1;
    assign out_leds     = ~pressed;

    for (genvar k = 0; k < W_KEYS; k++) begin : g_key
        logic [1:0]    sync;
        logic          raw_p;
        logic [1:0]    state, state_n;
        logic [DW-1:0] dcnt, dcnt_n;
        logic [HW-1:0] hcnt, hcnt_n;
        logic [RW-1:0] rcnt, rcnt_n;
        logic          press_n, release_n, repeat_n;
        logic          pressed_q, press_q, release_q, repeat_q;

        assign raw_p = ~sync[1];

        always_comb begin
            // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
            state_n   = state;
            dcnt_n    = dcnt;
            hcnt_n    = hcnt;
            rcnt_n    = rcnt;
            press_n   = 1'b0;
            release_n = 1'b0;
            repeat_n  = 1'b0;
            case (state)
                ST_RELEASED: begin
                    if (raw_p) begin
                        state_n = ST_PRESS_CHK;
                        dcnt_n  = '0;
                    end
                end
                ST_PRESS_CHK: begin
                    if (!raw_p) begin
                        state_n = ST_RELEASED;
                    end else if (dcnt == D_LAST) begin
                        state_n = ST_PRESSED;
                        press_n = 1'b1;
                        hcnt_n  = '0;
                        rcnt_n  = '0;
                    end else begin
                        dcnt_n = dcnt + DW'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!raw_p) begin
                        state_n = ST_RELEASE_CHK;
                        dcnt_n  = '0;
                    end else if (hcnt != H_SAT) begin
                        // hcnt stops at HOLD_CYCLES; rcnt paces the repeats from then on
                        hcnt_n = hcnt + HW'(1);
                        if (hcnt == H_PRE) begin
                            repeat_n = REP_EN;
                            rcnt_n   = '0;
                        end
                    end else if (rcnt == R_LAST) begin
                        repeat_n = REP_EN;
                        rcnt_n   = '0;
                    end else begin
                        rcnt_n = rcnt + RW'(1);
                    end
                end
                ST_RELEASE_CHK: begin
                    if (raw_p) begin
                        state_n = ST_PRESSED;
                    end else if (dcnt == D_LAST) begin
                        state_n   = ST_RELEASED;
                        release_n = 1'b1;
                    end else begin
                        dcnt_n = dcnt + DW'(1);
                    end
                end
                default: state_n = ST_RELEASED;
            endcase
        end

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) begin
                // NOTE: everything is reset here, synchronizer included, so a held key re-debounces as a new press.
                sync      <= 2'b11;
                state     <= ST_RELEASED;
                dcnt      <= '0;
                hcnt      <= '0;
                rcnt      <= '0;
                pressed_q <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                sync      <= {sync[0], in_keys[k]};
                state     <= state_n;
                dcnt      <= dcnt_n;
                hcnt      <= hcnt_n;
                rcnt      <= rcnt_n;
                pressed_q <= (state_n == ST_PRESSED) || (state_n == ST_RELEASE_CHK);
                press_q   <= press_n;
                release_q <= release_n;
                repeat_q  <= repeat_n;
            end
        end

        assign pressed[k]       = pressed_q;
        assign press_pulse[k]   = press_q;
        assign release_pulse[k] = release_q;
        assign repeat_pulse[k]  = repeat_q;
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE=4, HOLD=10, REPEAT=3, two keys.
module tb_key_debouncer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_keys;
    logic       vcc_for_keys;
    logic [1:0] pressed, press_pulse, release_pulse, repeat_pulse, out_leds;

    int n_vec = 0;
    int n_err = 0;

    key_debouncer #(
        .W_KEYS(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10),
        .REPEAT_CYCLES(3), .REPEAT_ENABLE(1)
    ) dut (
        .clk(clk), .rst(rst), .in_keys(in_keys), .vcc_for_keys(vcc_for_keys),
        .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse), .out_leds(out_leds)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_keys = 2'b11;
        tick();
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            n_vec++;
            if ({pressed, press_pulse, release_pulse, repeat_pulse} !== 8'h00) begin
                n_err++;
                $display("FAIL reset_outs edge %0d: got %b/%b/%b/%b want all 00", e,
                         pressed, press_pulse, release_pulse, repeat_pulse);
            end
            n_vec++;
            if (out_leds !== 2'b11 || vcc_for_keys !== 1'b1) begin
                n_err++;
                $display("FAIL reset_leds edge %0d: got leds=%b vcc=%b want 11/1", e, out_leds, vcc_for_keys);
            end
        end
    endtask

    task automatic test_press();
        logic [1:0] exp_pp, exp_pr;
        in_keys = 2'b10;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_pp = (e == 7) ? 2'b01 : 2'b00;
            exp_pr = (e >= 7) ? 2'b01 : 2'b00;
            n_vec++;
            if (press_pulse !== exp_pp) begin
                n_err++;
                $display("FAIL press_pulse edge %0d: got %b want %b", e, press_pulse, exp_pp);
            end
            n_vec++;
            if (pressed !== exp_pr || out_leds !== ~exp_pr) begin
                n_err++;
                $display("FAIL press_level edge %0d: got pressed=%b leds=%b want %b/%b", e, pressed, out_leds, exp_pr, ~exp_pr);
            end
            n_vec++;
            if (repeat_pulse !== 2'b00 || vcc_for_keys !== 1'b1) begin
                n_err++;
                $display("FAIL press_rep edge %0d: got rep=%b vcc=%b want 00/1", e, repeat_pulse, vcc_for_keys);
            end
        end
        in_keys = 2'b11;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_pp = (e == 7) ? 2'b01 : 2'b00;
            exp_pr = (e >= 7) ? 2'b00 : 2'b01;
            n_vec++;
            if (release_pulse !== exp_pp || pressed !== exp_pr) begin
                n_err++;
                $display("FAIL release edge %0d: got rel=%b pressed=%b want %b/%b", e, release_pulse, pressed, exp_pp, exp_pr);
            end
        end
    endtask

    task automatic test_glitch();
        logic [1:0] exp_pp;
        int         n_press;
        in_keys = 2'b10;
        for (int e = 1; e <= 3; e++) tick();
        in_keys = 2'b11;
        for (int e = 1; e <= 10; e++) begin
            tick();
            n_vec++;
            if (pressed !== 2'b00 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
                n_err++;
                $display("FAIL short_glitch edge %0d: got pressed=%b pp=%b rel=%b want 00", e, pressed, press_pulse, release_pulse);
            end
        end
        n_press = 0;
        for (int i = 0; i < 10; i++) begin
            in_keys = (i % 2 == 0) ? 2'b10 : 2'b11;
            tick();
            if (press_pulse[0]) n_press++;
            n_vec++;
            if (pressed !== 2'b00) begin
                n_err++;
                $display("FAIL bounce_level step %0d: got %b want 00", i, pressed);
            end
        end
        in_keys = 2'b10;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (press_pulse[0]) n_press++;
            exp_pp = (e == 7) ? 2'b01 : 2'b00;
            n_vec++;
            if (press_pulse !== exp_pp) begin
                n_err++;
                $display("FAIL bounce_press edge %0d: got %b want %b", e, press_pulse, exp_pp);
            end
        end
        n_vec++;
        if (n_press !== 1) begin
            n_err++;
            $display("FAIL bounce_count: got %0d press pulses want 1", n_press);
        end
        in_keys = 2'b11;
        for (int e = 1; e <= 9; e++) tick();
        n_vec++;
        if (pressed !== 2'b00) begin
            n_err++;
            $display("FAIL bounce_idle: got %b want 00", pressed);
        end
    endtask

    task automatic test_repeat();
        logic [1:0] exp_rp, exp_rel;
        int         k;
        in_keys = 2'b01;
        for (int e = 1; e <= 7; e++) tick();
        n_vec++;
        if (press_pulse !== 2'b10 || repeat_pulse !== 2'b00 || pressed !== 2'b10) begin
            n_err++;
            $display("FAIL rep_entry: got pp=%b rep=%b pressed=%b want 10/00/10", press_pulse, repeat_pulse, pressed);
        end
        for (k = 1; k <= 30; k++) begin
            tick();
            exp_rp = (k >= 10 && (k - 10) % 3 == 0) ? 2'b10 : 2'b00;
            n_vec++;
            if (repeat_pulse !== exp_rp) begin
                n_err++;
                $display("FAIL repeat k=%0d: got %b want %b", k, repeat_pulse, exp_rp);
            end
        end
        in_keys = 2'b11;
        for (int e = 1; e <= 10; e++) begin
            tick();
            k = 30 + e;
            // the key stays in PRESSED for two more edges while the synchronizer catches up
            exp_rp  = (e <= 2 && (k - 10) % 3 == 0) ? 2'b10 : 2'b00;
            exp_rel = (e == 7) ? 2'b10 : 2'b00;
            n_vec++;
            if (repeat_pulse !== exp_rp || release_pulse !== exp_rel) begin
                n_err++;
                $display("FAIL rep_release edge %0d: got rep=%b rel=%b want %b/%b", e, repeat_pulse, release_pulse, exp_rp, exp_rel);
            end
        end
    endtask

    task automatic test_both();
        logic [1:0] exp_rp, exp_rel, exp_pr;
        in_keys = 2'b00;
        for (int e = 1; e <= 7; e++) tick();
        n_vec++;
        if (press_pulse !== 2'b11 || pressed !== 2'b11) begin
            n_err++;
            $display("FAIL both_press: got pp=%b pressed=%b want 11/11", press_pulse, pressed);
        end
        for (int e = 1; e <= 3; e++) tick();
        in_keys = 2'b01;
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp_rp  = ((3 + e) >= 10 && ((3 + e) - 10) % 3 == 0) ? 2'b10 : 2'b00;
            exp_rel = (e == 7) ? 2'b01 : 2'b00;
            exp_pr  = (e >= 7) ? 2'b10 : 2'b11;
            n_vec++;
            if (release_pulse !== exp_rel || pressed !== exp_pr) begin
                n_err++;
                $display("FAIL both_release edge %0d: got rel=%b pressed=%b want %b/%b", e, release_pulse, pressed, exp_rel, exp_pr);
            end
            n_vec++;
            if (repeat_pulse !== exp_rp) begin
                n_err++;
                $display("FAIL both_repeat edge %0d: got %b want %b", e, repeat_pulse, exp_rp);
            end
        end
        in_keys = 2'b11;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_rel = (e == 7) ? 2'b10 : 2'b00;
            n_vec++;
            if (release_pulse !== exp_rel) begin
                n_err++;
                $display("FAIL both_release1 edge %0d: got %b want %b", e, release_pulse, exp_rel);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp_pp, exp_pr;
        in_keys = 2'b10;
        for (int e = 1; e <= 7; e++) tick();
        in_keys = 2'b11;
        for (int e = 1; e <= 3; e++) tick();
        n_vec++;
        if (pressed !== 2'b01 || release_pulse !== 2'b00) begin
            n_err++;
            $display("FAIL rchk_state: got pressed=%b rel=%b want 01/00", pressed, release_pulse);
        end
        in_keys = 2'b10;
        rst = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            tick();
            n_vec++;
            if (pressed !== 2'b00 || release_pulse !== 2'b00 || out_leds !== 2'b11) begin
                n_err++;
                $display("FAIL rst_mid edge %0d: got pressed=%b rel=%b leds=%b want 00/00/11", e, pressed, release_pulse, out_leds);
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_pp = (e == 7) ? 2'b01 : 2'b00;
            exp_pr = (e >= 7) ? 2'b01 : 2'b00;
            n_vec++;
            if (press_pulse !== exp_pp || pressed !== exp_pr || release_pulse !== 2'b00) begin
                n_err++;
                $display("FAIL rst_repress edge %0d: got pp=%b pressed=%b rel=%b want %b/%b/00", e, press_pulse, pressed, release_pulse, exp_pp, exp_pr);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_keys = 2'b11;
        test_reset();
        test_press();
        for (int e = 0; e < 3; e++) tick();
        test_glitch();
        test_repeat();
        for (int e = 0; e < 3; e++) tick();
        test_both();
        for (int e = 0; e < 3; e++) tick();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Input conditioner for the board's active-low push buttons: synchronizes the raw pins, debounces each key, and emits a clean active-high level plus one-cycle press, release and auto-repeat pulses.
- Sits between the key pins and user logic in every sequential lab; it also mirrors debounced state onto the active-low LEDs for bring-up.
- Keys are independent; all logic is replicated per key.

Parameters:
- W_KEYS, 2, number of keys handled.
- DEBOUNCE_CYCLES, 1000000, cycles a new level must stay stable before acceptance (20 ms at 50 MHz); must be ≥ 2.
- HOLD_CYCLES, 25000000, cycles in the pressed state before the first repeat pulse; must be ≥ 1.
- REPEAT_CYCLES, 5000000, period of subsequent repeat pulses; must be ≥ 1.
- REPEAT_ENABLE, 1, when 0 repeat_pulse is constant 0.

Ports:
- clk, in, 1, system clock (50 MHz oscillator).
- rst, in, 1, synchronous active-high reset.
- in_keys, in, W_KEYS, raw key pins, 0 = pressed, asynchronous to clk.
- vcc_for_keys, out, 1, constant 1; supplies the key pull-up side.
- pressed, out, W_KEYS, debounced level, 1 = pressed.
- press_pulse, out, W_KEYS, one-cycle pulse on accepted press.
- release_pulse, out, W_KEYS, one-cycle pulse on accepted release.
- repeat_pulse, out, W_KEYS, one-cycle auto-repeat pulse while held.
- out_leds, out, W_KEYS, equals ~pressed; 0 lights the LED.

Behaviour:
- Reset values (rst=1 at a clk edge):
  - Both synchronizer stages = 1 (not pressed).
  - State = RELEASED; all counters = 0.
  - pressed, press_pulse, release_pulse and repeat_pulse = 0; out_leds = all 1.
  - Reset mid-debounce or mid-hold discards progress and emits no release_pulse.
- Synchronizer: two flops per key. raw_p = ~sync2.
- Per-key state machine with debounce counter dcnt and hold counter hcnt:
  - RELEASED (pressed=0):
    - raw_p=1 → PRESS_CHK, dcnt=0.
  - PRESS_CHK (pressed=0):
    - raw_p=0 → RELEASED.
    - Otherwise, if dcnt==DEBOUNCE_CYCLES-1 → PRESSED, press_pulse=1 for one cycle, hcnt=0.
    - Otherwise dcnt++.
  - PRESSED (pressed=1):
    - raw_p=0 → RELEASE_CHK, dcnt=0.
    - Otherwise hcnt++ (saturating at its maximum).
  - RELEASE_CHK (pressed=1; hcnt frozen; no repeat pulses):
    - raw_p=1 → PRESSED, hcnt keeps its value.
    - Otherwise, if dcnt==DEBOUNCE_CYCLES-1 → RELEASED, release_pulse=1 for one cycle.
    - Otherwise dcnt++.
- Latency:
  - A clean press held stably makes pressed and press_pulse rise on clock edge DEBOUNCE_CYCLES+3, counting the first edge that samples in_keys low as edge 1.
  - Release is symmetric: pressed falls and release_pulse rises together.
- Glitches:
  - Any level change shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change.
  - A bounce restarts the check from dcnt=0 on the next entry.
- Repeat (REPEAT_ENABLE=1):
  - repeat_pulse=1 for one cycle when hcnt reaches HOLD_CYCLES.
  - Then once every REPEAT_CYCLES cycles spent in PRESSED.
  - repeat_pulse never coincides with press_pulse.
- All outputs are registered; out_leds is derived from the pressed register.
- A key held through reset is treated as a new press: press_pulse follows DEBOUNCE_CYCLES+3 edges after rst deasserts.
- Keys never interact; simultaneous events on different keys are all reported in the same cycle.

Test Plan:
All cases use DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, W_KEYS=2.
1. Reset, keys idle → all pulses 0, pressed=00, out_leds=11, vcc_for_keys=1 throughout.
2. in_keys[0] driven low and held → pressed[0] and press_pulse[0] rise on edge 7; press_pulse[0] lasts exactly 1 cycle; out_leds[0]=0.
3. in_keys[0] low for 3 cycles then high → no pulses; pressed stays 0. Bounce 0/1 alternating for 10 cycles, then stable low → exactly one press_pulse, 7 edges after the last transition.
4. Hold key 1 for 30 cycles after pressed rises → repeat_pulse[1] at 10, 13, 16, …, 28 cycles after entry into PRESSED, with no repeat pulse in the press cycle. Release → release_pulse[1] 7 edges after the rising pin, and repeats stop.
5. Press both keys on the same edge → press_pulse=11 in a single cycle. Release key 0 only → release_pulse=01; key 1 remains pressed and keeps repeating.
6. Assert rst while key 0 is in RELEASE_CHK → pressed=0 and no release_pulse. With the key still held after rst drops → press_pulse[0] on edge 7.
